// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: decodes SPI byte frames (command + optional data) into
// register-file writes and read responses, and flags malformed or aborted frames.
module spi_frame_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [31:0]       tx_word,
    output logic              frame_err,
    output logic [7:0]        err_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    state_t     post_state;

    logic       cs_meta;
    logic       cs_sync;
    logic       cs_prev;
    logic       cs_fall;
    logic       cs_rise;

    logic       bad;
    logic       bad_next;
    logic       post_bad;
    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic       rd_pend;

    logic       cmd_legal;
    logic       load_wr_addr;
    logic       load_rd_addr;
    logic       shift_data;
    logic       fire_wr;
    logic       fire_err;

    // Bits between bit 7 and the address field must all be zero.
    assign cmd_legal = ((rx_byte[6:0] >> ADDR_W) == 7'd0);

    assign cs_fall = cs_prev & ~cs_sync;
    assign cs_rise = ~cs_prev & cs_sync;

    // Two-flop synchronizer for cs_n plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta <= 1'b0;
            cs_sync <= 1'b0;
            cs_prev <= 1'b0;
        end else begin
            cs_meta <= cs_n;
            cs_sync <= cs_meta;
            cs_prev <= cs_sync;
        end
    end

    // Next-state logic: process any received byte first, then apply chip-select edges.
    always_comb begin
        post_state   = state;
        post_bad     = bad;
        cnt_next     = cnt;
        load_wr_addr = 1'b0;
        load_rd_addr = 1'b0;
        shift_data   = 1'b0;
        fire_wr      = 1'b0;
        fire_err     = 1'b0;
        state_next   = state;
        bad_next     = bad;

        case (state)
            IDLE: begin
                post_state = IDLE;
            end
            CMD: begin
                if (rx_valid) begin
                    if (!cmd_legal) begin
                        post_bad   = 1'b1;
                        post_state = DRAIN;
                    end else if (rx_byte[7]) begin
                        load_wr_addr = 1'b1;
                        cnt_next     = 2'd0;
                        post_state   = WDATA;
                    end else begin
                        load_rd_addr = 1'b1;
                        post_state   = DRAIN;
                    end
                end else begin
                    post_state = CMD;
                end
            end
            WDATA: begin
                if (rx_valid) begin
                    shift_data = 1'b1;
                    cnt_next   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        fire_wr    = 1'b1;
                        post_state = DRAIN;
                    end else begin
                        post_state = WDATA;
                    end
                end else begin
                    post_state = WDATA;
                end
            end
            DRAIN: begin
                post_state = DRAIN;
            end
            default: begin
                post_state = IDLE;
            end
        endcase

        // A falling edge anywhere (including a glitch mid-frame) starts a fresh frame.
        if (cs_fall) begin
            state_next = CMD;
            bad_next   = 1'b0;
        end else if (cs_rise) begin
            state_next = IDLE;
            bad_next   = 1'b0;
            fire_err   = (post_state != IDLE) && ((post_state != DRAIN) || post_bad);
        end else begin
            state_next = post_state;
            bad_next   = post_bad;
        end
    end

    // FSM state, bad flag and data-byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bad   <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            bad   <= bad_next;
            cnt   <= cnt_next;
        end
    end

    // Registered outputs: addresses, write data, strobes, response word and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= 32'd0;
            tx_word   <= 32'd0;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
            busy      <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            wr_en     <= fire_wr;
            frame_err <= fire_err;
            busy      <= (state_next != IDLE);
            rd_pend   <= load_rd_addr;
            if (load_wr_addr) begin
                wr_addr <= rx_byte[ADDR_W-1:0];
            end
            if (load_rd_addr) begin
                rd_addr <= rx_byte[ADDR_W-1:0];
            end
            // rd_data follows rd_addr combinationally, so capture one cycle after the address.
            if (rd_pend) begin
                tx_word <= rd_data;
            end
            if (shift_data) begin
                wr_data <= {wr_data[23:0], rx_byte};
            end
            if (fire_err && (err_cnt != 8'd255)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_spi_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [31:0] rd_data;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] tx_word;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    spi_frame_ctrl #(.ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .tx_word   (tx_word),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Register-file model providing combinational read data.
    logic [31:0] regs [16];
    assign rd_data = regs[rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: count write strobes and error pulses, remember the last write.
    int          wr_seen  = 0;
    int          err_seen = 0;
    logic [3:0]  last_wa  = 4'd0;
    logic [31:0] last_wd  = 32'd0;
    always @(negedge clk) begin
        if (wr_en) begin
            wr_seen <= wr_seen + 1;
            last_wa <= wr_addr;
            last_wd <= wr_data;
        end
        if (frame_err) begin
            err_seen <= err_seen + 1;
        end
    end

    // Reference model state.
    int          exp_err_total = 0;
    logic [31:0] exp_tx        = 32'd0;
    logic [7:0]  frame_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_err(input int n);
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick(1);
        rx_valid = 1'b0;
        tick(gap);
    endtask

    // Drive frame_q as one chip-select frame and check it against the frame-level model.
    task automatic run_frame(input int gap_max);
        int          w0;
        int          e0;
        logic        exp_wr;
        logic        exp_e;
        logic [3:0]  exp_wa;
        logic [31:0] exp_wd;
        w0     = wr_seen;
        e0     = err_seen;
        exp_wr = 1'b0;
        exp_e  = 1'b0;
        exp_wa = 4'd0;
        exp_wd = 32'd0;
        if (frame_q.size() == 0) begin
            exp_e = 1'b1;
        end else if (frame_q[0][6:4] != 3'd0) begin
            exp_e = 1'b1;
        end else if (frame_q[0][7]) begin
            if (frame_q.size() >= 5) begin
                exp_wr = 1'b1;
                exp_wa = frame_q[0][3:0];
                exp_wd = {frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
            end else begin
                exp_e = 1'b1;
            end
        end else begin
            exp_tx = regs[frame_q[0][3:0]];
        end
        if (exp_e) begin
            exp_err_total++;
        end

        cs_n = 1'b0;
        tick(4);
        check("busy_in_frame", 32'(busy), 32'd1);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], $urandom_range(0, gap_max));
        end
        cs_n = 1'b1;
        tick(6);

        check("wr_count", 32'(wr_seen - w0), 32'(exp_wr));
        if (exp_wr) begin
            check("wr_addr", 32'(last_wa), 32'(exp_wa));
            check("wr_data", last_wd, exp_wd);
        end
        check("err_pulses", 32'(err_seen - e0), 32'(exp_e));
        check("tx_word", tx_word, exp_tx);
        check("err_cnt", 32'(err_cnt), sat_err(exp_err_total));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int          w0;
        int          e0;
        logic [7:0]  cmd;
        logic [3:0]  a;
        int          kind;

        rst      = 1'b1;
        cs_n     = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
        for (int i = 0; i < 16; i++) begin
            regs[i] = $urandom;
        end
        regs[5] = 32'h1234_5678;

        // Reset state.
        tick(3);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_strobes", {29'd0, wr_en, frame_err, busy}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Write frame.
        frame_q = '{8'h83, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(1);

        // Read frame with latency checks and trailing bytes.
        w0   = wr_seen;
        e0   = err_seen;
        cs_n = 1'b0;
        tick(4);
        send_byte(8'h05, 0);
        check("read_rd_addr", 32'(rd_addr), 32'd5);
        check("read_tx_old", tx_word, exp_tx);
        tick(1);
        check("read_tx_new", tx_word, 32'h1234_5678);
        exp_tx = 32'h1234_5678;
        send_byte(8'h81, 1);
        send_byte(8'h22, 0);
        send_byte(8'h7F, 1);
        cs_n = 1'b1;
        tick(6);
        check("read_no_wr", 32'(wr_seen - w0), 32'd0);
        check("read_no_err", 32'(err_seen - e0), 32'd0);
        check("read_tx_hold", tx_word, exp_tx);

        // Aborted write, then illegal command.
        frame_q = '{8'h81, 8'h11, 8'h22};
        run_frame(1);
        frame_q = '{8'h70};
        run_frame(1);

        // Fourth data byte coinciding with the synchronized rising chip select.
        w0   = wr_seen;
        e0   = err_seen;
        cs_n = 1'b0;
        tick(4);
        send_byte(8'h82, 1);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 1);
        send_byte(8'hBA, 1);
        cs_n = 1'b1;
        tick(2);
        send_byte(8'hBE, 0);
        tick(5);
        check("coinc_wr", 32'(wr_seen - w0), 32'd1);
        check("coinc_wr_addr", 32'(last_wa), 32'd2);
        check("coinc_wr_data", last_wd, 32'hCAFE_BABE);
        check("coinc_no_err", 32'(err_seen - e0), 32'd0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            frame_q.delete();
            if ($urandom_range(0, 9) != 0) begin
                kind = $urandom_range(0, 2);
                a    = 4'($urandom_range(0, 15));
                case (kind)
                    0:       cmd = {4'h8, a};
                    1:       cmd = {4'h0, a};
                    default: cmd = 8'($urandom);
                endcase
                frame_q.push_back(cmd);
                repeat ($urandom_range(0, 6)) frame_q.push_back(8'($urandom));
            end
            run_frame(2);
        end

        // Error counter saturation.
        for (int f = 0; f < 260; f++) begin
            frame_q.delete();
            run_frame(0);
        end
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Reset in the middle of a write frame.
        w0   = wr_seen;
        e0   = err_seen;
        cs_n = 1'b0;
        tick(4);
        send_byte(8'h84, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_data", wr_data, 32'd0);
        check("mid_rst_tx_word", tx_word, 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_strobes", {29'd0, wr_en, frame_err, busy}, 32'd0);
        tick(1);
        rst = 1'b0;
        exp_err_total = 0;
        exp_tx        = 32'd0;
        send_byte(8'h03, 1);
        send_byte(8'h04, 1);
        cs_n = 1'b1;
        tick(6);
        check("mid_rst_no_wr", 32'(wr_seen - w0), 32'd0);
        check("mid_rst_no_err", 32'(err_seen - e0), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);

        // Clean write after the reset.
        frame_q = '{8'h8A, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        run_frame(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
